// File: rtl/mul32_seq_pkg.sv
// Shared types, widths and step decode for the iterative 32x32 multiplier.
package mul32_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } mul32_state_t;

    localparam int unsigned MUL32_STEPS  = 4;
    localparam int unsigned MUL32_HALF_W = 16;
    localparam int unsigned MUL32_PROD_W = 64;

    typedef struct packed {
        logic       x_hi;
        logic       y_hi;
        logic [5:0] shift;
    } step_sel_t;

    // Partial-product order: xl*yl, xl*yh, xh*yl, xh*yh.
    function automatic step_sel_t step_sel(input logic [1:0] step);
        step_sel_t s;
        case (step)
            2'd0:    s = '{x_hi: 1'b0, y_hi: 1'b0, shift: 6'd0};
            2'd1:    s = '{x_hi: 1'b0, y_hi: 1'b1, shift: 6'd16};
            2'd2:    s = '{x_hi: 1'b1, y_hi: 1'b0, shift: 6'd16};
            default: s = '{x_hi: 1'b1, y_hi: 1'b1, shift: 6'd32};
        endcase
        return s;
    endfunction

    // Lowest enabled step index at or above 'from'.
    function automatic logic [1:0] next_enabled(input logic [MUL32_STEPS-1:0] mask,
                                                input logic [2:0] from);
        logic [1:0] r;
        logic       found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MUL32_STEPS; i++) begin
            if (!found && i >= 32'(from) && mask[i]) begin
                r     = 2'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic has_enabled(input logic [MUL32_STEPS-1:0] mask,
                                         input logic [2:0] from);
        return |(mask >> from);
    endfunction

endpackage

// File: rtl/mul32_seq_mult.sv
// Existing 16x16 unsigned combinational multiplier, time-shared by mul32_seq.
import mul32_seq_pkg::*;

module multiplier16b (
    input  logic [MUL32_HALF_W-1:0]   a,
    input  logic [MUL32_HALF_W-1:0]   b,
    output logic [2*MUL32_HALF_W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/mul32_seq.sv
// Iterative 32x32->64 unsigned multiplier over four 16x16 partial products.
// Define MUL32_SEQ_ZERO_SKIP_EN to skip steps whose operand halves contain a zero.
import mul32_seq_pkg::*;

module mul32_seq #(
    parameter int HALF_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] z,
    output logic        busy
);

    mul32_state_t              state;
    logic [1:0]                step;
    logic [2*HALF_W-1:0]       xr;
    logic [2*HALF_W-1:0]       yr;
    logic [MUL32_PROD_W-1:0]   acc;

    step_sel_t                 sel;
    logic [HALF_W-1:0]         a_op;
    logic [HALF_W-1:0]         b_op;
    logic [2*HALF_W-1:0]       pp;
    logic [MUL32_PROD_W-1:0]   addend;

    logic [1:0]                first_step;
    logic [1:0]                next_step;
    logic                      last_step;
    logic                      accept_empty;

    always_comb begin
        sel    = step_sel(step);
        a_op   = sel.x_hi ? xr[2*HALF_W-1:HALF_W] : xr[HALF_W-1:0];
        b_op   = sel.y_hi ? yr[2*HALF_W-1:HALF_W] : yr[HALF_W-1:0];
        addend = '0;
        addend[2*HALF_W-1:0] = pp;
        addend = addend << sel.shift;
    end

    multiplier16b u_mult (
        .a (a_op),
        .b (b_op),
        .p (pp)
    );

`ifdef MUL32_SEQ_ZERO_SKIP_EN
    logic [MUL32_STEPS-1:0] mask;
    logic [MUL32_STEPS-1:0] accept_mask;

    // Mask bit order matches step_sel: {hh, hl, lh, ll}.
    always_comb begin
        accept_mask = {(|x[31:16]) & (|y[31:16]),
                       (|x[31:16]) & (|y[15:0]),
                       (|x[15:0])  & (|y[31:16]),
                       (|x[15:0])  & (|y[15:0])};
        accept_empty = (accept_mask == '0);
        first_step   = next_enabled(accept_mask, 3'd0);
        next_step    = next_enabled(mask, {1'b0, step} + 3'd1);
        last_step    = !has_enabled(mask, {1'b0, step} + 3'd1);
    end
`else
    always_comb begin
        accept_empty = 1'b0;
        first_step   = '0;
        next_step    = step + 2'd1;
        last_step    = (step == 2'(MUL32_STEPS - 1));
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            acc       <= '0;
            xr        <= '0;
            yr        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef MUL32_SEQ_ZERO_SKIP_EN
            mask      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        xr       <= x;
                        yr       <= y;
                        acc      <= '0;
                        step     <= first_step;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
`ifdef MUL32_SEQ_ZERO_SKIP_EN
                        mask     <= accept_mask;
`endif
                        if (accept_empty) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc <= acc + addend;
                    if (last_step) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        step <= next_step;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign z = acc;

endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: handshake-level model plus directed vectors.
module tb_mul32_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] z;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mul32_seq #(.HALF_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Number of partial-product cycles the spec requires for an operand pair.
    function automatic int n_steps(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL32_SEQ_ZERO_SKIP_EN
        int n;
        n = 0;
        if (a[15:0]  != 0 && b[15:0]  != 0) n++;
        if (a[15:0]  != 0 && b[31:16] != 0) n++;
        if (a[31:16] != 0 && b[15:0]  != 0) n++;
        if (a[31:16] != 0 && b[31:16] != 0) n++;
        return n;
`else
        return 4;
`endif
    endfunction

    // Transaction-level model: busy from accept to handshake, valid after N cycles.
    bit          m_busy  = 1'b0;
    bit          m_valid = 1'b0;
    int          m_wait  = 0;
    logic [63:0] m_z     = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_wait  <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy  <= 1'b1;
                m_z     <= {32'd0, x} * {32'd0, y};
                m_wait  <= n_steps(x, y);
                m_valid <= (n_steps(x, y) == 0);
            end
        end else if (!m_valid) begin
            m_wait  <= m_wait - 1;
            m_valid <= (m_wait == 1);
        end else if (out_ready) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check64("flags{in_ready,out_valid,busy}", {61'd0, in_ready, out_valid, busy},
                    {61'd0, !m_busy, m_valid, m_busy});
            if (m_valid) check64("z_vs_model", z, m_z);
        end
    end

    // Called at a negedge; leaves at a negedge after the output handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] lit_z, input int lit_lat, input int hold);
        int n;
        int lat;
        x = a; y = b; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        check64("accept_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        lat = 1;
        in_valid = 1'b0;
        x = ~a; y = ~b;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        check64("latency", 64'(lat), 64'(lit_lat));
        check64("z_literal", z, lit_z);
        check64("model_pin", m_z, lit_z);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check64("bp_z", z, lit_z);
            check64("bp_flags", {62'd0, out_valid, in_ready}, {62'd0, 1'b1, 1'b0});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check64("post_hs", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    endtask

    initial begin
        int n;
        int lat;
        // Reset together with a pending request: reset must win.
        in_valid = 1'b1; x = 32'h0000_0003; y = 32'h0000_0007;
        repeat (3) @(negedge clk);
        check64("reset_state", {z, 61'd0, in_ready, out_valid, busy},
                {64'd0, 61'd0, 1'b1, 1'b0, 1'b0});
        rst = 1'b0; in_valid = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check64("rst_wins_busy", 64'(busy), 64'd0);

`ifdef MUL32_SEQ_ZERO_SKIP_EN
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 0);
        run_op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 2, 0);
        run_op(32'h0000_FFFF, 32'hFFFF_0000, 64'h0000_FFFE_0001_0000, 2, 3);
        run_op(32'h0000_0000, 32'h1234_5678, 64'h0, 1, 0);
`else
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 0);
        run_op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 5, 0);
        run_op(32'h0000_FFFF, 32'hFFFF_0000, 64'h0000_FFFE_0001_0000, 5, 3);
        run_op(32'h0000_0000, 32'h1234_5678, 64'h0, 5, 0);
`endif

        // Reset in the middle of an operation.
        x = 32'h1234_5678; y = 32'h0000_0001; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check64("mid_reset_idle", {61'd0, in_ready, out_valid, busy}, {61'd0, 1'b1, 1'b0, 1'b0});
        repeat (8) begin
            @(negedge clk);
            check64("mid_reset_no_valid", 64'(out_valid), 64'd0);
        end
`ifdef MUL32_SEQ_ZERO_SKIP_EN
        run_op(32'h1234_5678, 32'h0000_0001, 64'h0000_0000_1234_5678, 3, 0);
`else
        run_op(32'h1234_5678, 32'h0000_0001, 64'h0000_0000_1234_5678, 5, 0);
`endif

        // Back-to-back with in_valid held and out_ready high.
        x = 32'h0000_0002; y = 32'h8000_0000; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        x = 32'h0000_0003; y = 32'h0000_0005;
        lat = 1;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        check64("b2b_first_z", z, 64'h0000_0001_0000_0000);
        @(negedge clk);
        check64("b2b_accept_next", {63'd0, in_ready}, {63'd0, 1'b1});
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
`ifdef MUL32_SEQ_ZERO_SKIP_EN
        check64("b2b_second_lat", 64'(lat), 64'd2);
`else
        check64("b2b_second_lat", 64'(lat), 64'd5);
`endif
        check64("b2b_second_z", z, 64'd15);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul32_seq.md
# mul32_seq

Iterative 32×32→64 unsigned multiplier that time-shares a single `multiplier16b` instance over four partial-product steps under a small FSM. It sits between a requester issuing operand pairs and a consumer of 64-bit products, with valid/ready handshakes on both sides. It reuses the existing 16-bit combinational multiplier rather than building a 32-bit array.

## Interface
- `HALF_W`, 16, operand half-width; only 16 is supported because it must match `multiplier16b`.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous reset, active-high
- `in_valid`  in  1  operand pair offered
- `in_ready`  out  1  block can accept operands
- `x`  in  32  multiplicand, unsigned
- `y`  in  32  multiplier, unsigned
- `out_valid`  out  1  product available
- `out_ready`  in  1  consumer takes product
- `z`  out  64  product x*y
- `busy`  out  1  high in any state other than IDLE

## Operation
- States are IDLE, MUL and DONE. Step counter `step` is 2 bits.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch `x`, `y`; clear the 64-bit accumulator; set `step` to the first enabled step; go to MUL.
- **MUL:** each cycle drives one partial product through `multiplier16b`:
  - step 0: xl*yl, shifted by 0.
  - step 1: xl*yh, shifted by 16.
  - step 2: xh*yl, shifted by 16.
  - step 3: xh*yh, shifted by 32.
  - Each cycle: acc ← acc + (pp << shift), full 64-bit add. No overflow is possible; the final value is exact.
  - After the last enabled step, go to DONE.
- **DONE**
  - `out_valid`=1 and `z`=acc, held stable until `out_ready`.
  - On `out_valid & out_ready`: go to IDLE.
- `in_ready` is high only in IDLE. No accept occurs in DONE, even when `out_ready` is high.
- Operands change on `x`/`y` after acceptance have no effect, because they are latched.
- `in_valid` while busy is ignored. The requester must hold it until `in_ready`.

## Timing
- **Reset values:** state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `z`=0, acc=0, `step`=0.
- **Latency:** accept at cycle T leads to `out_valid` at T+N+1, where N is the number of enabled steps. Without the config macro, N=4, so `out_valid` rises at T+5.
- **Throughput:** with an immediate `out_ready`, one product per N+2 cycles (6 baseline).
- `out_valid` falls on the cycle after the handshake, and `in_ready` rises on that same cycle.
- **Back-pressure:** DONE is held indefinitely. `z` must not change while `out_valid`=1 and `out_ready`=0.
- **Reset mid-MUL or mid-DONE:** the operation is abandoned. The next cycle is IDLE with `out_valid`=0, and no partial result is emitted.
- `rst` together with `in_valid`: reset wins and the operands are not accepted.

## Configuration
- `MUL32_SEQ_ZERO_SKIP_EN` defined:
  - At accept, compute a 4-bit enable mask. A step is enabled iff both of its 16-bit operand halves are non-zero.
  - MUL visits only enabled steps in ascending order.
  - If the mask is 0 (either operand half pair zero for every step, e.g. x==0), go straight from IDLE to DONE with acc=0. `out_valid` then rises at T+1.
- Undefined:
  - The mask is forced to 4'b1111 and the latency is fixed at 5.
  - No mask logic is synthesized.

## Structure
- Package `mul32_seq_pkg` contains:
  - state enum `mul32_state_t` (IDLE, MUL, DONE);
  - `MUL32_STEPS`=4;
  - `MUL32_HALF_W`=16;
  - `MUL32_PROD_W`=64;
  - a function mapping step to (x-half select, y-half select, shift).
- Sub-module: one `multiplier16b` instance fed by muxed operand halves. FSM, accumulator and mask stay in `mul32_seq`.

## Test plan
- **Full-scale operands:** after reset, x=0xFFFFFFFF, y=0xFFFFFFFF, accepted at T → `out_valid` at T+5, z=0xFFFFFFFE00000001.
- **High-halves only:** x=0x00010000, y=0x00010000 → z=0x0000000100000000.
  - Baseline latency is 5.
  - With ZERO_SKIP, only step 3 runs, so latency is 2.
- **Mixed halves with back-pressure:** x=0x0000FFFF, y=0xFFFF0000 → z=0x0000FFFE00010000. Hold `out_ready`=0 for 3 cycles: `z`/`out_valid` stay stable and `in_ready`=0 throughout.
- **Zero operand:** x=0x00000000, y=0x12345678 → z=0.
  - Baseline latency is 5.
  - With ZERO_SKIP, `out_valid` at T+1.
- **Reset mid-operation:** accept x=0x12345678, y=0x00000001, assert `rst` at T+2 → IDLE at T+3, `out_valid` never asserts. A re-issue then yields z=0x0000000012345678.
- **Back-to-back:** two requests with `in_valid` held high and `out_ready`=1 → the second is accepted exactly on the cycle after the first output handshake.
